nios_solo_nios2_gen2_0_cpu_div_cell: RTL and testbench

- Iterative radix-2 restoring divider for the Nios II core. It is the inverse-direction companion of the multiplier partial-product cell.
- Accepts dividend/divisor from the E stage with a start pulse.
- Runs one quotient bit per clock, applies sign correction, and returns quotient and remainder with a one-cycle done strobe.
- The CPU holds its pipeline on busy.

---
 rtl/nios_solo_nios2_gen2_0_cpu_div_cell_if.sv | 25 ++
 rtl/nios_solo_nios2_gen2_0_cpu_div_cell.sv | 133 +++++++++++++
 tb/tb_nios_solo_nios2_gen2_0_cpu_div_cell.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios_solo_nios2_gen2_0_cpu_div_cell_if.sv
// Divider request/response bundle between the E stage (master) and the
// iterative divide cell (slave).
interface nios_solo_nios2_gen2_0_cpu_div_cell_if #(
    parameter int DW = 32
);
    logic [DW-1:0] E_src1;
    logic [DW-1:0] E_src2;
    logic          E_signed;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    modport master (
        output E_src1, E_src2, E_signed, start, abort,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  E_src1, E_src2, E_signed, start, abort,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/nios_solo_nios2_gen2_0_cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per clock on the
// operand magnitudes, followed by a single sign-correction cycle that loads
// the result registers and a one-cycle done strobe.
module nios_solo_nios2_gen2_0_cpu_div_cell #(
    parameter int DW = 32
) (
    input logic clk,
    input logic reset,
    nios_solo_nios2_gen2_0_cpu_div_cell_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] rem_r;
    logic [DW-1:0] dvd_r;
    logic [DW-1:0] dsr_r;
    logic [CW-1:0] cnt;
    logic          q_neg;
    logic          r_neg;
    logic          div_zero;
    logic [DW-1:0] quotient_r;
    logic [DW-1:0] remainder_r;

    logic          accept;
    logic          sign1;
    logic          sign2;
    logic          src2_zero;
    logic [DW-1:0] abs1;
    logic [DW-1:0] abs2;
    logic [DW:0]   shifted;
    logic [DW:0]   trial;
    logic [DW-1:0] q_fix;
    logic [DW-1:0] r_fix;

    // A new request is taken when the cell is idle or finishing, unless a
    // flush arrives in the same cycle.
    assign accept    = ((state == IDLE) || (state == DONE)) && bus.start && !bus.abort;
    assign sign1     = bus.E_signed & bus.E_src1[DW-1];
    assign sign2     = bus.E_signed & bus.E_src2[DW-1];
    assign src2_zero = (bus.E_src2 == '0);
    assign abs1      = sign1 ? -bus.E_src1 : bus.E_src1;
    assign abs2      = sign2 ? -bus.E_src2 : bus.E_src2;

    // The partial remainder never reaches the divisor, so DW+1 bits hold
    // the shifted value and the sign of the trial subtraction.
    assign shifted = {rem_r, dvd_r[DW-1]};
    assign trial   = shifted - {1'b0, dsr_r};

    // On divide by zero the dividend register still holds the raw operand,
    // which is returned unmodified as the remainder.
    assign q_fix = div_zero ? '1 : (q_neg ? -dvd_r : dvd_r);
    assign r_fix = div_zero ? dvd_r : (r_neg ? -rem_r : rem_r);

    assign bus.busy      = (state == CALC) || (state == FIX);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state_nxt = src2_zero ? FIX : CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        state_nxt = FIX;
                    end
                end
                FIX:     state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture, shift/subtract iteration and result load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            div_zero    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (accept) begin
            rem_r    <= '0;
            dvd_r    <= src2_zero ? bus.E_src1 : abs1;
            dsr_r    <= abs2;
            cnt      <= CW'(DW - 1);
            q_neg    <= sign1 ^ sign2;
            r_neg    <= sign1;
            div_zero <= src2_zero;
        end else if ((state == CALC) && !bus.abort) begin
            if (!trial[DW]) begin
                rem_r <= trial[DW-1:0];
                dvd_r <= {dvd_r[DW-2:0], 1'b1};
            end else begin
                rem_r <= shifted[DW-1:0];
                dvd_r <= {dvd_r[DW-2:0], 1'b0};
            end
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end else if ((state == FIX) && !bus.abort) begin
            quotient_r  <= q_fix;
            remainder_r <= r_fix;
        end
    end
endmodule

// File: tb/tb_nios_solo_nios2_gen2_0_cpu_div_cell.sv
// Self-checking bench for the iterative divide cell: directed corner cases,
// handshake/abort/reset sequences and randomized operands against a plain
// arithmetic reference model.
module tb_nios_solo_nios2_gen2_0_cpu_div_cell;
    localparam int DW = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] last_q;
    logic [31:0] last_r;

    nios_solo_nios2_gen2_0_cpu_div_cell_if #(.DW(DW)) bus ();

    nios_solo_nios2_gen2_0_cpu_div_cell #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference division straight from the arithmetic definition.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0];
            r = lr[31:0];
        end
    endtask

    // Present a request for one cycle, then scramble the operand inputs.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        bus.E_src1   = a;
        bus.E_src2   = b;
        bus.E_signed = sgn;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.E_src1   = $urandom;
        bus.E_src2   = $urandom;
        bus.E_signed = 1'($urandom_range(0, 1));
    endtask

    // Count cycles until done, noting whether busy ever dropped early.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check_output(tag, 64'(seen), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] eq;
        logic [31:0] er;
        ref_div(a, b, sgn, eq, er);
        check_output({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check_output({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
        check_output({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
        last_q = eq;
        last_r = er;
    endtask

    task automatic apply_stimulus(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int lat;
        bit busy_ok;
        launch(a, b, sgn);
        wait_done(lat, busy_ok);
        check_output({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'(DW + 2));
        check_output({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check_result(tag, a, b, sgn);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          sel;

        checks = 0;
        errors = 0;
        last_q = '0;
        last_r = '0;
        reset        = 1'b1;
        bus.E_src1   = '0;
        bus.E_src2   = '0;
        bus.E_signed = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_done", 64'(bus.done), 64'd0);
        check_output("reset_quotient", 64'(bus.quotient), 64'd0);
        check_output("reset_remainder", 64'(bus.remainder), 64'd0);
        reset = 1'b0;

        apply_stimulus("u_100_7", 32'd100, 32'd7, 1'b0);
        apply_stimulus("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
        apply_stimulus("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
        apply_stimulus("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        apply_stimulus("u_div0", 32'h1234_5678, 32'd0, 1'b0);
        apply_stimulus("s_div0", 32'hFFFF_FFF0, 32'd0, 1'b1);
        apply_stimulus("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        apply_stimulus("u_5_max", 32'd5, 32'hFFFF_FFFF, 1'b0);

        // Start pulses while busy must not disturb the running operation.
        launch(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.E_src1 = 32'd50;
            bus.E_src2 = 32'd3;
            bus.start  = 1'b1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check_output("ignore_start_latency", 64'(lat), 64'(DW - 1));
        check_result("ignore_start", 32'd100, 32'd7, 1'b0);

        // Back-to-back: new request accepted in the done cycle.
        bus.E_src1   = 32'd9;
        bus.E_src2   = 32'd2;
        bus.E_signed = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check_output("b2b_latency", 64'(lat), 64'(DW + 2));
        check_result("b2b", 32'd9, 32'd2, 1'b0);

        // Abort in the tenth CALC cycle.
        launch(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_output("abort_busy", 64'(bus.busy), 64'd0);
        watch_no_done(40, "abort_no_done");
        check_output("abort_hold_q", 64'(bus.quotient), 64'(last_q));
        check_output("abort_hold_r", 64'(bus.remainder), 64'(last_r));

        // Abort and start together in IDLE.
        @(negedge clk);
        bus.E_src1 = 32'd77;
        bus.E_src2 = 32'd5;
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        watch_no_done(40, "abort_start_no_done");
        check_output("abort_start_hold_q", 64'(bus.quotient), 64'(last_q));

        // Asynchronous reset in the middle of CALC.
        launch(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midreset_busy", 64'(bus.busy), 64'd0);
        check_output("midreset_quotient", 64'(bus.quotient), 64'd0);
        check_output("midreset_remainder", 64'(bus.remainder), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        last_q = '0;
        last_r = '0;
        watch_no_done(40, "midreset_no_done");

        // Randomized operands, including zero and small divisors.
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = 32'($urandom_range(1, 20));
            else if (sel == 7) b = $urandom >> $urandom_range(0, 31);
            else               b = $urandom;
            sgn = 1'($urandom_range(0, 1));
            apply_stimulus("rand", a, b, sgn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
